// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes, ALU ops, mux selects.
// Pure declarations, no logic, so there is no latency.
// No handshakes are declared here, so no backpressure either.
package pa_riscv;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    JAL,
    BEQ,
    TRAP
  } e_state;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  localparam logic       ADR_PC      = 1'b0;
  localparam logic       ADR_ALUOUT  = 1'b1;
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the controller and the datapath: decoded IR fields and status in, selects/enables out.
// Wires only, so there is no latency.
// Memory stalls travel on i_memReady; the controller holds its state until that input goes high.
interface multicycle_controller_if;
  logic [6:0] i_operand;
  logic [2:0] i_funct3;
  logic       i_funct7bit5;
  logic       i_zeroFlag;
  logic       i_memReady;
  logic       o_pcWriteEn;
  logic       o_adrSrc;
  logic       o_memReq;
  logic       o_memWriteEn;
  logic       o_irWriteEn;
  logic       o_regWriteEn;
  logic [1:0] o_aluSrcA;
  logic [1:0] o_aluSrcB;
  logic [3:0] o_aluLogicOperation;
  logic [1:0] o_resultSrc;
  logic       o_illegalInstr;

  modport master (
    input  i_operand, i_funct3, i_funct7bit5, i_zeroFlag, i_memReady,
    output o_pcWriteEn, o_adrSrc, o_memReq, o_memWriteEn, o_irWriteEn, o_regWriteEn,
           o_aluSrcA, o_aluSrcB, o_aluLogicOperation, o_resultSrc, o_illegalInstr
  );

  modport slave (
    output i_operand, i_funct3, i_funct7bit5, i_zeroFlag, i_memReady,
    input  o_pcWriteEn, o_adrSrc, o_memReq, o_memWriteEn, o_irWriteEn, o_regWriteEn,
           o_aluSrcA, o_aluSrcB, o_aluLogicOperation, o_resultSrc, o_illegalInstr
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps funct3/funct7[5] to an ALU operation and flags encodings the ALU cannot execute.
// Purely combinational, so there is no latency.
// Takes no handshake and applies no backpressure.
module alu_decoder
  import pa_riscv::*;
(
  input  logic [6:0] i_operand,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  output logic [3:0] o_op,
  output logic       o_legal
);

  logic w_isR;
  assign w_isR = (i_operand == OP_R);

  // funct7[5] picks SUB only for register ops (it is an immediate bit for ADDI); it marks arithmetic shifts for both
  always_comb begin
    o_op    = ALU_ADD;
    o_legal = 1'b1;
    case (i_funct3)
      3'b000:  o_op = (w_isR && i_funct7bit5) ? ALU_SUB : ALU_ADD;
      3'b111:  o_op = ALU_AND;
      3'b110:  o_op = ALU_OR;
      3'b100:  o_op = ALU_XOR;
      3'b010:  o_op = ALU_SLT;
      3'b001:  o_op = ALU_SLL;
      3'b101: begin
        o_op    = ALU_SRL;
        o_legal = ~i_funct7bit5;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multicycle RV32I core: drives every datapath select and write enable.
// Moore outputs; an instruction takes 3 to 5 cycles with zero-wait memory (beq 3, lw 5).
// Stalls in FETCH/MEMREAD/MEMWRITE until i_memReady; enables are forced low while reset is asserted.
module multicycle_controller
  import pa_riscv::*;
(
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  multicycle_controller_if.master bus
);

  e_state     r_state;
  e_state     w_next;
  logic       r_illegal;
  logic [3:0] w_aluOp;
  logic       w_aluLegal;

  logic       w_pcWriteEn, w_adrSrc, w_memReq, w_memWriteEn, w_irWriteEn, w_regWriteEn;
  logic [1:0] w_aluSrcA, w_aluSrcB, w_resultSrc;
  logic [3:0] w_aluLogicOperation;

  alu_decoder u_alu_decoder (
    .i_operand    (bus.i_operand),
    .i_funct3     (bus.i_funct3),
    .i_funct7bit5 (bus.i_funct7bit5),
    .o_op         (w_aluOp),
    .o_legal      (w_aluLegal)
  );

  // State register; reset returns to FETCH regardless of the instruction in flight
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) r_state <= FETCH;
    else           r_state <= w_next;
  end

  // Sticky illegal flag, raised on the transition into TRAP and cleared only by reset
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)          r_illegal <= 1'b0;
    else if (w_next == TRAP) r_illegal <= 1'b1;
  end

  // Next state; every decode failure is resolved in DECODE so later states need not re-check
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:    if (bus.i_memReady) w_next = DECODE;
      DECODE: begin
        case (bus.i_operand)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = w_aluLegal ? EXECR : TRAP;
          OP_I:         w_next = w_aluLegal ? EXECI : TRAP;
          OP_JAL:       w_next = JAL;
          OP_BRANCH:    w_next = (bus.i_funct3 == 3'b000) ? BEQ : TRAP;
          default:      w_next = TRAP;
        endcase
      end
      MEMADR:   w_next = (bus.i_operand == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.i_memReady) w_next = MEMWB;
      MEMWB:    w_next = FETCH;
      MEMWRITE: if (bus.i_memReady) w_next = FETCH;
      EXECR:    w_next = ALUWB;
      EXECI:    w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      JAL:      w_next = ALUWB;
      BEQ:      w_next = FETCH;
      TRAP:     w_next = TRAP;
      default:  w_next = TRAP;
    endcase
  end

  // Per-state datapath controls; anything not listed for a state stays at its idle value
  always_comb begin
    w_pcWriteEn         = 1'b0;
    w_adrSrc            = ADR_PC;
    w_memReq            = 1'b0;
    w_memWriteEn        = 1'b0;
    w_irWriteEn         = 1'b0;
    w_regWriteEn        = 1'b0;
    w_aluSrcA           = SRCA_PC;
    w_aluSrcB           = SRCB_RS2;
    w_aluLogicOperation = ALU_ADD;
    w_resultSrc         = RES_ALUOUT;
    case (r_state)
      FETCH: begin
        w_memReq    = 1'b1;
        w_aluSrcB   = SRCB_FOUR;
        w_resultSrc = RES_ALU;
        w_irWriteEn = bus.i_memReady;
        w_pcWriteEn = bus.i_memReady;
      end
      DECODE: begin
        w_aluSrcA = SRCA_OLDPC;
        w_aluSrcB = SRCB_IMM;
      end
      MEMADR: begin
        w_aluSrcA = SRCA_RS1;
        w_aluSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        w_memReq = 1'b1;
        w_adrSrc = ADR_ALUOUT;
      end
      MEMWB: begin
        w_resultSrc  = RES_MEMDATA;
        w_regWriteEn = 1'b1;
      end
      MEMWRITE: begin
        w_memReq     = 1'b1;
        w_memWriteEn = 1'b1;
        w_adrSrc     = ADR_ALUOUT;
      end
      EXECR: begin
        w_aluSrcA           = SRCA_RS1;
        w_aluSrcB           = SRCB_RS2;
        w_aluLogicOperation = w_aluOp;
      end
      EXECI: begin
        w_aluSrcA           = SRCA_RS1;
        w_aluSrcB           = SRCB_IMM;
        w_aluLogicOperation = w_aluOp;
      end
      ALUWB: w_regWriteEn = 1'b1;
      JAL: begin
        w_aluSrcA   = SRCA_OLDPC;
        w_aluSrcB   = SRCB_FOUR;
        w_pcWriteEn = 1'b1;
      end
      BEQ: begin
        w_aluSrcA           = SRCA_RS1;
        w_aluSrcB           = SRCB_RS2;
        w_aluLogicOperation = ALU_SUB;
        w_pcWriteEn         = bus.i_zeroFlag;
      end
      default: ;
    endcase
  end

  // Gating with the reset pin makes every enable drop the moment reset asserts, before the flops settle
  assign bus.o_pcWriteEn         = w_pcWriteEn  & i_arst_n;
  assign bus.o_memReq            = w_memReq     & i_arst_n;
  assign bus.o_memWriteEn        = w_memWriteEn & i_arst_n;
  assign bus.o_irWriteEn         = w_irWriteEn  & i_arst_n;
  assign bus.o_regWriteEn        = w_regWriteEn & i_arst_n;
  assign bus.o_adrSrc            = w_adrSrc;
  assign bus.o_aluSrcA           = w_aluSrcA;
  assign bus.o_aluSrcB           = w_aluSrcB;
  assign bus.o_aluLogicOperation = w_aluLogicOperation;
  assign bus.o_resultSrc         = w_resultSrc;
  assign bus.o_illegalInstr      = r_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle comparison of all outputs against hand-written vectors.
// Inputs change just after each falling edge; outputs are sampled 1 ns later.
// Memory stalls are produced by holding i_memReady low for chosen cycles.
module tb_multicycle_controller;

  logic clk;
  logic arst_n;
  int   checks;
  int   failures;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .i_clk    (clk),
    .i_arst_n (arst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcW, adrSrc, memReq, memWE, irWE, regWE, srcA[2], srcB[2], op[4], resSrc[2], illegal}
  logic [16:0] obs;
  assign obs = {bus.o_pcWriteEn, bus.o_adrSrc, bus.o_memReq, bus.o_memWriteEn, bus.o_irWriteEn,
                bus.o_regWriteEn, bus.o_aluSrcA, bus.o_aluSrcB, bus.o_aluLogicOperation,
                bus.o_resultSrc, bus.o_illegalInstr};

  function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic req,
                                     input logic mw, input logic ir, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [3:0] op, input logic [1:0] res, input logic ill);
    return {pcw, adr, req, mw, ir, rw, a, b, op, res, ill};
  endfunction

  function automatic logic [16:0] e_fetch(input logic rdy);
    return ev(rdy, 0, 1, 0, rdy, 0, 2'b00, 2'b10, 4'd0, 2'b10, 0);
  endfunction
  function automatic logic [16:0] e_reset();
    return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'd0, 2'b10, 0);
  endfunction
  function automatic logic [16:0] e_decode();
    return ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [16:0] e_memadr();
    return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [16:0] e_memread();
    return ev(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [16:0] e_memwb();
    return ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'd0, 2'b01, 0);
  endfunction
  function automatic logic [16:0] e_memwrite();
    return ev(0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [16:0] e_execr(input logic [3:0] op);
    return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, op, 2'b00, 0);
  endfunction
  function automatic logic [16:0] e_execi(input logic [3:0] op);
    return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, op, 2'b00, 0);
  endfunction
  function automatic logic [16:0] e_aluwb();
    return ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [16:0] e_jal();
    return ev(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [16:0] e_beq(input logic z);
    return ev(z, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'd1, 2'b00, 0);
  endfunction
  function automatic logic [16:0] e_trap();
    return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 2'b00, 1);
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    #1;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  // Check the current cycle, then move to the next falling edge (one state transition later)
  task automatic cyc(input string tag, input logic [16:0] exp);
    chk(tag, exp);
    @(negedge clk);
  endtask

  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    bus.i_operand    = opc;
    bus.i_funct3     = f3;
    bus.i_funct7bit5 = f7;
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    arst_n = 1'b0;
    chk(tag, e_reset());
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    arst_n   = 1'b0;
    bus.i_zeroFlag = 1'b0;
    bus.i_memReady = 1'b0;
    instr(7'b0000000, 3'b000, 1'b0);
    #2;
    chk("reset", e_reset());
    @(negedge clk);
    arst_n = 1'b1;

    // R-type SUB, zero-wait memory: 4 cycles, regWriteEn only in the last
    instr(7'b0110011, 3'b000, 1'b1);
    bus.i_memReady = 1'b1;
    cyc("sub_fetch", e_fetch(1));
    cyc("sub_decode", e_decode());
    cyc("sub_execr", e_execr(4'd1));
    cyc("sub_aluwb", e_aluwb());

    // lw with three wait cycles in MEMREAD: 8 cycles total
    instr(7'b0000011, 3'b010, 1'b0);
    cyc("lw_fetch", e_fetch(1));
    cyc("lw_decode", e_decode());
    cyc("lw_memadr", e_memadr());
    bus.i_memReady = 1'b0;
    cyc("lw_wait1", e_memread());
    cyc("lw_wait2", e_memread());
    cyc("lw_wait3", e_memread());
    bus.i_memReady = 1'b1;
    cyc("lw_memread", e_memread());
    cyc("lw_memwb", e_memwb());

    // beq taken then not taken
    instr(7'b1100011, 3'b000, 1'b0);
    bus.i_zeroFlag = 1'b1;
    cyc("beq1_fetch", e_fetch(1));
    cyc("beq1_decode", e_decode());
    cyc("beq1_taken", e_beq(1));
    bus.i_zeroFlag = 1'b0;
    cyc("beq0_fetch", e_fetch(1));
    cyc("beq0_decode", e_decode());
    cyc("beq0_not_taken", e_beq(0));

    // sw with FETCH stalled for 2 cycles
    instr(7'b0100011, 3'b010, 1'b0);
    bus.i_memReady = 1'b0;
    cyc("sw_fetch_wait1", e_fetch(0));
    cyc("sw_fetch_wait2", e_fetch(0));
    bus.i_memReady = 1'b1;
    cyc("sw_fetch", e_fetch(1));
    bus.i_memReady = 1'b0;
    cyc("sw_decode", e_decode());
    cyc("sw_memadr", e_memadr());
    bus.i_memReady = 1'b1;
    cyc("sw_memwrite", e_memwrite());

    // jal, xori (funct7bit5 ignored outside shifts), srli
    instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_fetch", e_fetch(1));
    cyc("jal_decode", e_decode());
    cyc("jal_jal", e_jal());
    cyc("jal_aluwb", e_aluwb());
    instr(7'b0010011, 3'b100, 1'b1);
    cyc("xori_fetch", e_fetch(1));
    cyc("xori_decode", e_decode());
    cyc("xori_execi", e_execi(4'd4));
    cyc("xori_aluwb", e_aluwb());
    instr(7'b0010011, 3'b101, 1'b0);
    cyc("srli_fetch", e_fetch(1));
    cyc("srli_decode", e_decode());
    cyc("srli_execi", e_execi(4'd7));
    cyc("srli_aluwb", e_aluwb());

    // SRA is unsupported: trap straight from DECODE
    instr(7'b0110011, 3'b101, 1'b1);
    cyc("sra_fetch", e_fetch(1));
    cyc("sra_decode", e_decode());
    cyc("sra_trap", e_trap());
    pulse_reset("sra_reset");

    // SYSTEM opcode: trap holds 20 cycles while memReady is asserted, then reset clears it
    instr(7'b1110011, 3'b000, 1'b0);
    cyc("sys_fetch", e_fetch(1));
    cyc("sys_decode", e_decode());
    for (int i = 0; i < 20; i++) cyc($sformatf("sys_trap%0d", i), e_trap());
    pulse_reset("sys_reset");
    instr(7'b0110011, 3'b111, 1'b0);
    cyc("and_fetch", e_fetch(1));
    cyc("and_decode", e_decode());
    cyc("and_execr", e_execr(4'd2));
    cyc("and_aluwb", e_aluwb());

    // Reset asserted inside a stalled MEMWRITE: enables drop before the next clock edge
    instr(7'b0100011, 3'b010, 1'b0);
    cyc("swr_fetch", e_fetch(1));
    cyc("swr_decode", e_decode());
    cyc("swr_memadr", e_memadr());
    bus.i_memReady = 1'b0;
    cyc("swr_memwrite", e_memwrite());
    pulse_reset("swr_async_reset");
    bus.i_memReady = 1'b1;
    cyc("swr_refetch", e_fetch(1));
    cyc("swr_redecode", e_decode());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
